// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo: write/read requests, data and
// occupancy/error flags grouped so the FIFO and its user share one port.
interface param_fifo_if #(
  parameter int fifo_width = 32,
  parameter int fifo_depth = 8
);
  localparam int CW = $clog2(fifo_depth) + 1;

  logic                  flush;
  logic                  push;
  logic                  pop;
  logic [fifo_width-1:0] data_in;
  logic                  clr_err;
  logic [fifo_width-1:0] data_out;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, push, pop, data_in, clr_err,
    input  data_out, fifo_full, fifo_empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, push, pop, data_in, clr_err,
    output data_out, fifo_full, fifo_empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers, almost-full/empty
// thresholds, flush, and sticky overflow/underflow flags.
module param_fifo #(
  parameter int fifo_depth = 8,
  parameter int fifo_width = 32,
  parameter int af_level   = fifo_depth - 2,
  parameter int ae_level   = 1
) (
  input  logic        clk,
  input  logic        reset,
  param_fifo_if.slave bus
);
  localparam int AW = $clog2(fifo_depth);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(af_level);
  localparam logic [PW-1:0] AE_LVL = PW'(ae_level);
  localparam logic [PW-1:0] ONE    = PW'(1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [fifo_width-1:0] mem_q [fifo_depth];

  logic          full, empty, push_ok, pop_ok, wr_en;
  logic [PW-1:0] count_w;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count_w = wr_ptr_q - rd_ptr_q;

  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign pop_ok  = bus.pop && !empty;
  assign push_ok = bus.push && (!full || pop_ok);
  assign wr_en   = push_ok && !bus.flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
      // Setting comes after clearing so a coincident set wins.
      if (bus.push && !push_ok) overflow_d  = 1'b1;
      if (bus.pop  && !pop_ok)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
  end

  // Empty masks the read so unwritten storage never reaches data_out.
  assign bus.data_out     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.count        = count_w;
  assign bus.almost_full  = (count_w >= AF_LVL);
  assign bus.almost_empty = (count_w <= AE_LVL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: directed vector table, then randomized traffic
// checked against a queue-based reference model.
module tb_param_fifo;
  localparam int D  = 8;
  localparam int W  = 32;
  localparam int AF = 6;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_fifo_if #(.fifo_width(W), .fifo_depth(D)) bus ();

  param_fifo #(.fifo_depth(D), .fifo_width(W), .af_level(AF), .ae_level(AE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst, fl, pu, po, clr;
    logic [31:0] din;
    int          cnt;
    logic [31:0] dout;
    logic        ovf, unf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  int   mq[$];
  logic m_ovf, m_unf;

  function automatic void add(logic r, logic f, logic pu, logic po, logic c,
                              logic [31:0] din, int cnt, logic [31:0] dout,
                              logic ovf, logic unf);
    vec_t v;
    v.rst = r; v.fl = f; v.pu = pu; v.po = po; v.clr = c; v.din = din;
    v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(logic r, logic f, logic pu, logic po, logic c, logic [31:0] din);
    reset = r; bus.flush = f; bus.push = pu; bus.pop = po; bus.clr_err = c; bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(int idx, int cnt, logic [31:0] dout, logic ovf, logic unf);
    chk("count",        idx, 32'(bus.count),     32'(cnt));
    chk("data_out",     idx, bus.data_out,       dout);
    chk("fifo_full",    idx, 32'(bus.fifo_full),    32'(cnt == D));
    chk("fifo_empty",   idx, 32'(bus.fifo_empty),   32'(cnt == 0));
    chk("almost_full",  idx, 32'(bus.almost_full),  32'(cnt >= AF));
    chk("almost_empty", idx, 32'(bus.almost_empty), 32'(cnt <= AE));
    chk("overflow",     idx, 32'(bus.overflow),  32'(ovf));
    chk("underflow",    idx, 32'(bus.underflow), 32'(unf));
  endtask

  // Reference: occupancy is the queue length; acceptance follows the FIFO rules directly.
  function automatic void model_step(logic r, logic f, logic pu, logic po, logic c, logic [31:0] din);
    bit pop_ok, push_ok;
    if (r) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else if (f) begin
      mq.delete();
      if (c) begin m_ovf = 0; m_unf = 0; end
    end else begin
      pop_ok  = po && (mq.size() > 0);
      push_ok = pu && ((mq.size() < D) || pop_ok);
      if (c) begin m_ovf = 0; m_unf = 0; end
      if (pu && !push_ok) m_ovf = 1;
      if (po && !pop_ok)  m_unf = 1;
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back(int'(din));
    end
  endfunction

  initial begin
    reset = 1'b1; bus.flush = 0; bus.push = 0; bus.pop = 0; bus.clr_err = 0; bus.data_in = '0;

    // Reset, then fill with A0..A7 and overflow once.
    add(1,0,0,0,0, 32'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++) add(0,0,1,0,0, 32'hA0 + i, i + 1, 32'hA0, 0, 0);
    add(0,0,1,0,0, 32'hA8, 8, 32'hA0, 1, 0);
    // Drain in order, then underflow once.
    for (int k = 0; k < 8; k++) add(0,0,0,1,0, 32'h0, 7 - k, (k < 7) ? 32'hA1 + k : 32'h0, 1, 0);
    add(0,0,0,1,0, 32'h0, 0, 32'h0, 1, 1);
    add(0,0,0,0,1, 32'h0, 0, 32'h0, 0, 0);
    // Refill, then push+pop while full.
    for (int i = 0; i < 8; i++) add(0,0,1,0,0, 32'hA0 + i, i + 1, 32'hA0, 0, 0);
    add(0,0,1,1,0, 32'hB0, 8, 32'hA1, 0, 0);
    for (int k = 0; k < 8; k++)
      add(0,0,0,1,0, 32'h0, 7 - k, (k < 6) ? 32'hA2 + k : ((k == 6) ? 32'hB0 : 32'h0), 0, 0);
    // Push+pop while empty: no bypass, push lands, pop rejected.
    add(0,0,1,1,0, 32'hC0, 1, 32'hC0, 0, 1);
    add(0,0,0,1,0, 32'h0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 5; i++) add(0,0,1,0,0, 32'hD0 + i, i + 1, 32'hD0, 0, 1);
    add(0,0,0,0,1, 32'h0, 5, 32'hD0, 0, 0);
    // Flush wins over push/pop and never raises flags.
    add(0,1,1,1,0, 32'hE0, 0, 32'h0, 0, 0);
    add(0,1,0,1,0, 32'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++) add(0,0,1,0,0, 32'hF0 + i, i + 1, 32'hF0, 0, 0);
    add(0,0,1,0,0, 32'hF8, 8, 32'hF0, 1, 0);
    add(0,1,0,0,0, 32'h0, 0, 32'h0, 1, 0);
    add(0,0,0,1,0, 32'h0, 0, 32'h0, 1, 1);
    add(0,0,0,0,1, 32'h0, 0, 32'h0, 0, 0);
    // Set and clear together: set wins.
    add(0,0,0,1,1, 32'h0, 0, 32'h0, 0, 1);
    // Mid-operation reset discards contents and flags.
    add(0,0,1,0,0, 32'h11, 1, 32'h11, 0, 1);
    add(0,0,1,0,0, 32'h12, 2, 32'h11, 0, 1);
    add(1,0,1,1,1, 32'h13, 0, 32'h0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].fl, vecs[i].pu, vecs[i].po, vecs[i].clr, vecs[i].din);
      check_all(i, vecs[i].cnt, vecs[i].dout, vecs[i].ovf, vecs[i].unf);
    end

    // Randomized traffic against the reference model.
    model_step(1,0,0,0,0,0);
    apply(1,0,0,0,0,0);
    check_all(1000, mq.size(), 32'h0, m_ovf, m_unf);
    for (int n = 0; n < 400; n++) begin
      logic pu, po, fl, cl;
      logic [31:0] din;
      int bias;
      bias = ((n / 40) % 2 == 0) ? 75 : 30;
      pu  = ($urandom_range(0, 99) < bias);
      po  = ($urandom_range(0, 99) < (100 - bias));
      fl  = ($urandom_range(0, 99) < 2);
      cl  = ($urandom_range(0, 99) < 5);
      din = $urandom;
      model_step(0, fl, pu, po, cl, din);
      apply(0, fl, pu, po, cl, din);
      check_all(2000 + n, mq.size(), (mq.size() > 0) ? 32'(mq[0]) : 32'h0, m_ovf, m_unf);
      chk("count_bound", 2000 + n, 32'(bus.count <= D), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have the parameter fifo_depth, default 8: number of entries; a power of two, at least 2.
REQ-002 The block SHALL have the parameter fifo_width, default 32: data word width in bits.
REQ-003 The block SHALL have the parameter af_level, default fifo_depth-2: almost_full threshold, valid range 1..fifo_depth.
REQ-004 The block SHALL have the parameter ae_level, default 1: almost_empty threshold, valid range 0..fifo_depth-1.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-006 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have the port flush, input, 1 bit: synchronous empty request; storage contents are not cleared.
REQ-008 The block SHALL have the port push, input, 1 bit: write request.
REQ-009 The block SHALL have the port pop, input, 1 bit: read request.
REQ-010 The block SHALL have the port data_in, input, fifo_width bits: write data.
REQ-011 The block SHALL have the port clr_err, input, 1 bit: clears the sticky error flags.
REQ-012 The block SHALL have the port data_out, output, fifo_width bits: head entry (show-ahead).
REQ-013 The block SHALL have the port fifo_full, output, 1 bit: count == fifo_depth.
REQ-014 The block SHALL have the port fifo_empty, output, 1 bit: count == 0.
REQ-015 The block SHALL have the port almost_full, output, 1 bit: count >= af_level.
REQ-016 The block SHALL have the port almost_empty, output, 1 bit: count <= ae_level.
REQ-017 The block SHALL have the port count, output, $clog2(fifo_depth)+1 bits: current occupancy.
REQ-018 The block SHALL have the port overflow, output, 1 bit: sticky; set when a push is rejected.
REQ-019 The block SHALL have the port underflow, output, 1 bit: sticky; set when a pop is rejected.

Function
REQ-020 Pointer structure SHALL be wr_ptr and rd_ptr, each $clog2(fifo_depth)+1 bits; the low bits address storage and the MSB is the wrap bit.
REQ-021 fifo_full SHALL be (MSBs differ, low bits equal), fifo_empty SHALL be (pointers identical), and both are decoded combinationally from the registered pointers.
REQ-022 count SHALL equal wr_ptr - rd_ptr, modulo 2^($clog2(fifo_depth)+1).
REQ-023 Push acceptance: push_ok = push && (!fifo_full || pop_ok); an accepted push writes data_in at wr_ptr[low] and increments wr_ptr on the same edge.
REQ-024 Pop acceptance: pop_ok = pop && !fifo_empty; an accepted pop increments rd_ptr on the edge.
REQ-025 Full with push and pop together SHALL accept both: count unchanged, the head word is read out, and the new word is written into the freed slot.
REQ-026 Empty with push and pop together SHALL accept the push, reject the pop, set underflow, and make count 1; there is no same-cycle bypass.
REQ-027 Non-full, non-empty with push and pop together SHALL accept both and leave count unchanged.
REQ-028 data_out SHALL equal storage[rd_ptr[low]] combinationally when !fifo_empty, and all zeros when fifo_empty.
REQ-029 Write-to-read latency SHALL be 1 cycle: a word pushed into an empty FIFO appears on data_out in the cycle after the push edge.
REQ-030 Pointer wrap-around SHALL be natural binary rollover of the full pointer width, with no special casing.
REQ-031 overflow SHALL be set on an edge where push && !push_ok, and underflow on an edge where pop && !pop_ok.
REQ-032 Both flags SHALL hold until clr_err or reset; if set and clear coincide, set wins.
REQ-033 flush SHALL force wr_ptr and rd_ptr to 0 on the edge, with priority over push and pop.
REQ-034 During flush, push and pop SHALL be ignored and SHALL NOT set the error flags.
REQ-035 Storage SHALL be unreset flops or RAM; no output SHALL depend on unwritten storage contents.

Reset
REQ-036 On a reset edge, wr_ptr, rd_ptr, overflow and underflow SHALL go to 0; reset overrides flush, push, pop and clr_err.
REQ-037 After reset, outputs SHALL be: fifo_empty=1, fifo_full=0, count=0, almost_empty=1, almost_full=0, data_out=0, overflow=0, underflow=0.
REQ-038 Reset asserted mid-operation SHALL discard all contents, and the outputs SHALL match REQ-037 in the cycle after the edge.

Verification (fifo_depth=8, fifo_width=32, af_level=6, ae_level=1)
REQ-039 Bench SHALL cover: reset, then push 0xA0..0xA7 on 8 cycles -> fifo_full=1, count=8, almost_full from count 6, data_out=0xA0; a ninth push sets overflow=1 and leaves count=8.
REQ-040 Bench SHALL cover: from full, pop 8 cycles -> data_out sequence 0xA0..0xA7, fifo_empty=1, data_out=0; a ninth pop sets underflow=1.
REQ-041 Bench SHALL cover: full FIFO, push=1, pop=1 with data_in=0xB0 -> count stays 8, head advances to 0xA1, and 0xB0 emerges as the 8th subsequent pop.
REQ-042 Bench SHALL cover: empty FIFO, push=1, pop=1 with data_in=0xC0 -> count=1, data_out=0xC0 next cycle, underflow=1.
REQ-043 Bench SHALL cover: 20 push/pop cycles with random-overlap traffic crossing pointer wrap twice -> scoreboard order matches, and count never exceeds 8.
REQ-044 Bench SHALL cover: count=5, then flush=1 with push=1 -> count=0, fifo_empty=1, no flag set; then clr_err=1 clears previously set overflow and underflow next cycle.
